route_opt_stream: RTL and testbench

- Parametrised successor to the fixed 8-lane route rewriter.
- Accepts one full route as BEATS beats of LANES city IDs, applies one optimisation move (identity, or-opt forward, or-opt backward, 2-opt reversal), then streams out the rewritten route.
- Sits between the replica route store and the exchange/energy pipeline.
- Uses a lane-banked flop buffer, so any K/L pair and any lane count work without per-case select tables.

---
 rtl/route_opt_stream.sv | 172 +++++++++++++++++
 tb/tb_route_opt_stream.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/route_opt_stream.sv
// route_opt_stream: buffers one LANES*BEATS route, applies NOP/or-opt/2-opt, streams it out.
// Optional ROUTE_OPT_CHECKSUM_EN adds an in/out city-ID sum check on chk_err.
module route_opt_stream #(
  parameter int LANES = 8,
  parameter int BEATS = 4,
  parameter int CW = 7,
  parameter int PW = $clog2(LANES*BEATS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_mode,
  input  logic [PW-1:0]         cmd_k,
  input  logic [PW-1:0]         cmd_l,
  output logic                  cmd_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*CW-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*CW-1:0]   out_data,
  output logic                  chk_err
);
  localparam int N = LANES*BEATS;
  localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam logic [PW:0] LN = (PW+1)'(LANES);
  localparam logic [PW:0] NN = (PW+1)'(N);
  localparam logic [BW-1:0] LAST = BW'(BEATS-1);
  localparam logic [1:0] M_NOP = 2'd0, M_OR0 = 2'd1, M_OR1 = 2'd2, M_TWO = 2'd3;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  state_t state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [PW-1:0] k_q, k_d, l_q, l_d, pos;
  logic [CW-1:0] p_q, p_d;
  logic [BW-1:0] wr_q, wr_d, ob_q, ob_d, ld_beat, pbeat;
  logic [LW-1:0] plane;
  logic cmd_ready_q, cmd_ready_d, in_ready_q, in_ready_d;
  logic out_valid_q, out_valid_d, cmd_err_q, cmd_err_d;
  logic [LANES*CW-1:0] out_q, out_d, ld_data;
  logic [CW-1:0] mem_q [LANES][BEATS];
  logic cmd_acc, in_acc, out_acc, legal, ld_en, done;
  assign cmd_acc = cmd_ready_q && cmd_valid;
  assign in_acc = in_ready_q && in_valid;
  assign out_acc = out_valid_q && out_ready;
  assign legal = cmd_mode == M_NOP || (cmd_k < cmd_l && {1'b0, cmd_l} < NN);
  assign ld_beat = out_valid_q ? ob_q + BW'(1) : '0;
  assign ld_en = state_q == DRAIN && (!out_valid_q || (out_ready && ob_q != LAST));
  assign done = state_q == DRAIN && out_acc && ob_q == LAST;
  // p holds the single city that leaves its neighbourhood: in[K] for OR0, in[L] for OR1
  assign pos = mode_q == M_OR0 ? k_q : l_q;
  assign pbeat = BW'({1'b0, pos} / LN);
  assign plane = LW'({1'b0, pos} % LN);
  for (genvar g = 0; g < LANES; g++) begin : gl
    logic [PW-1:0] i, s;
    logic use_p;
    logic [LW-1:0] bk;
    logic [BW-1:0] ad;
    assign i = PW'((PW+1)'(ld_beat) * LN + (PW+1)'(g));
    assign use_p = (mode_q == M_OR0 && i == l_q) || (mode_q == M_OR1 && i == k_q);
    assign s = (mode_q == M_OR0 && k_q <= i && i < l_q) ? i + PW'(1) :
               (mode_q == M_OR1 && k_q < i && i <= l_q) ? i - PW'(1) :
               (mode_q == M_TWO && k_q <= i && i <= l_q) ? k_q + l_q - i : i;
    assign bk = LW'({1'b0, s} % LN);
    assign ad = BW'({1'b0, s} / LN);
    assign ld_data[g*CW +: CW] = use_p ? p_q : mem_q[bk][ad];
  end
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    k_d = k_q;
    l_d = l_q;
    p_d = p_q;
    wr_d = wr_q;
    ob_d = ob_q;
    out_d = out_q;
    out_valid_d = out_valid_q;
    cmd_err_d = cmd_acc && !legal;
    if (cmd_acc) begin
      state_d = LOAD;
      mode_d = legal ? cmd_mode : M_NOP;
      k_d = cmd_k;
      l_d = cmd_l;
      wr_d = '0;
    end
    if (in_acc) begin
      wr_d = wr_q + BW'(1);
      p_d = wr_q == pbeat ? in_data[plane*CW +: CW] : p_q;
      state_d = wr_q == LAST ? DRAIN : LOAD;
    end
    if (ld_en) begin
      out_d = ld_data;
      out_valid_d = 1'b1;
      ob_d = ld_beat;
    end
    if (done) begin
      out_valid_d = 1'b0;
      state_d = IDLE;
    end
    cmd_ready_d = state_d == IDLE;
    in_ready_d = state_d == LOAD;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q <= '0;
      k_q <= '0;
      l_q <= '0;
      p_q <= '0;
      wr_q <= '0;
      ob_q <= '0;
      out_q <= '0;
      out_valid_q <= 1'b0;
      cmd_err_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      k_q <= k_d;
      l_q <= l_d;
      p_q <= p_d;
      wr_q <= wr_d;
      ob_q <= ob_d;
      out_q <= out_d;
      out_valid_q <= out_valid_d;
      cmd_err_q <= cmd_err_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q <= in_ready_d;
    end
  end
  always_ff @(posedge clk) begin
    if (in_acc)
      for (int j = 0; j < LANES; j++) mem_q[j][wr_q] <= in_data[j*CW +: CW];
  end
  assign cmd_ready = cmd_ready_q;
  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data = out_q;
  assign cmd_err = cmd_err_q;
`ifdef ROUTE_OPT_CHECKSUM_EN
  localparam int SW = CW + PW;
  logic [SW-1:0] sin_q, sin_d, sout_q, sout_d, in_sum, out_sum;
  logic chk_q, chk_d;
  always_comb begin
    in_sum = '0;
    out_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      in_sum = in_sum + SW'(in_data[j*CW +: CW]);
      out_sum = out_sum + SW'(out_q[j*CW +: CW]);
    end
    sin_d = cmd_acc ? '0 : in_acc ? sin_q + in_sum : sin_q;
    sout_d = cmd_acc ? '0 : out_acc ? sout_q + out_sum : sout_q;
    chk_d = cmd_acc ? 1'b0 : chk_q || (done && sin_q != sout_d);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sin_q <= '0;
      sout_q <= '0;
      chk_q <= 1'b0;
    end else begin
      sin_q <= sin_d;
      sout_q <= sout_d;
      chk_q <= chk_d;
    end
  end
  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_route_opt_stream.sv
// tb_route_opt_stream: randomized route rewrites checked against a queue-based route model.
module tb_route_opt_stream;
  localparam int LANES = 8, BEATS = 4, CW = 7, N = LANES*BEATS, PW = $clog2(N);
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_err, in_valid = 0, in_ready;
  logic out_valid, out_ready = 0, chk_err;
  logic [1:0] cmd_mode = 0;
  logic [PW-1:0] cmd_k = 0, cmd_l = 0;
  logic [LANES*CW-1:0] in_data = 0, out_data;
  always #5 clk = ~clk;
  route_opt_stream #(.LANES(LANES), .BEATS(BEATS), .CW(CW), .PW(PW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_k(cmd_k), .cmd_l(cmd_l), .cmd_err(cmd_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .chk_err(chk_err));
  int errors = 0, checks = 0;
  int din[N], exp_o[N];
  logic [LANES*CW-1:0] got[BEATS];
  int lat, err_cnt, stab, crv, beats, extra;
  logic cr_after, ov_after;

  task automatic model(input int mode, input int k, input int l);
    int q[$];
    int t, a, b;
    bit legal;
    legal = mode == 0 || (k < l && l < N);
    q = {};
    for (int i = 0; i < N; i++) q.push_back(din[i]);
    if (legal && mode == 1) begin
      t = q[k]; q.delete(k); q.insert(l, t);
    end else if (legal && mode == 2) begin
      t = q[l]; q.delete(l); q.insert(k, t);
    end else if (legal && mode == 3) begin
      a = k; b = l;
      while (a < b) begin
        t = q[a]; q[a] = q[b]; q[b] = t; a++; b--;
      end
    end
    for (int i = 0; i < N; i++) exp_o[i] = q[i];
  endtask

  function automatic logic [LANES*CW-1:0] exp_beat(input int b);
    logic [LANES*CW-1:0] v;
    for (int j = 0; j < LANES; j++) v[j*CW +: CW] = CW'(exp_o[b*LANES+j]);
    return v;
  endfunction

  // dmode: 0 identity data, 1 random; bp: 0 always ready, 1 alternate, 2 random.
  // rst_beat >= 0 returns as soon as that beat is on out_data.
  task automatic do_route(input int mode, input int k, input int l, input int dmode,
                          input int bp, input bit flip, input int rst_beat);
    int w, b, n;
    bit hs, ov, acc, prev_stall, tog;
    logic [LANES*CW-1:0] od, prev_d;
    for (int i = 0; i < N; i++) din[i] = dmode == 1 ? int'($urandom_range(0, 127)) : i;
    model(mode, k, l);
    err_cnt = 0; stab = 0; crv = 0; beats = 0; extra = 0; lat = -1;
    prev_stall = 0; prev_d = '0; tog = 1;
    w = 0;
    while (!cmd_ready && w < 20) begin @(posedge clk); #1; w++; end
    checks++;
    if (!cmd_ready) begin errors++; $display("FAIL cmd_wait cmd_ready=%b required=1", cmd_ready); end
    cmd_valid = 1; cmd_mode = 2'(mode); cmd_k = PW'(k); cmd_l = PW'(l);
    @(posedge clk); #1;
    cmd_valid = 0;
    err_cnt += int'(cmd_err);
    b = 0; w = 0;
    while (b < BEATS && w < 50) begin
      for (int j = 0; j < LANES; j++) in_data[j*CW +: CW] = CW'(din[b*LANES+j]);
      in_valid = 1;
      hs = in_ready;
      @(posedge clk); #1;
      err_cnt += int'(cmd_err);
      if (hs) b++;
      w++;
    end
    in_valid = 0;
    checks++;
    if (b != BEATS) begin errors++; $display("FAIL load_beats got=%0d required=%0d", b, BEATS); end
`ifdef ROUTE_OPT_CHECKSUM_EN
    if (flip) dut.mem_q[0][BEATS-1] = dut.mem_q[0][BEATS-1] ^ CW'(1);
`endif
    n = 0;
    while (beats < BEATS && n < 200) begin
      out_ready = bp == 0 ? 1'b1 : bp == 1 ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      ov = out_valid; od = out_data;
      if (ov && lat < 0) lat = n + 1;
      if (rst_beat >= 0 && beats == rst_beat && ov) return;
      if (ov && prev_stall && od !== prev_d) stab++;
      if (cmd_ready) crv++;
      err_cnt += int'(cmd_err);
      acc = ov && out_ready;
      @(posedge clk); #1;
      n++;
      if (acc) begin got[beats] = od; beats++; end
      prev_stall = ov && !out_ready;
      prev_d = od;
    end
    cr_after = cmd_ready; ov_after = out_valid;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (out_valid) extra++;
    end
    checks++;
    if (beats != BEATS) begin errors++; $display("FAIL drain_beats got=%0d required=%0d", beats, BEATS); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got=%b required=0", cmd_ready); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b required=0", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b required=0", out_valid); end
    if (cmd_err !== 1'b0) begin errors++; $display("FAIL rst_cmd_err got=%b required=0", cmd_err); end
    if (chk_err !== 1'b0) begin errors++; $display("FAIL rst_chk_err got=%b required=0", chk_err); end
    reset = 0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got=%b required=1", cmd_ready); end
  endtask

  task automatic test_nop();
    do_route(0, 7, 3, 0, 0, 0, -1);
    for (int b = 0; b < BEATS; b++) begin
      checks++;
      if (got[b] !== exp_beat(b)) begin errors++; $display("FAIL nop beat%0d got=%h required=%h", b, got[b], exp_beat(b)); end
    end
    checks += 4;
    if (lat != 2) begin errors++; $display("FAIL nop_latency got=%0d required=2", lat); end
    if (err_cnt != 0) begin errors++; $display("FAIL nop_cmd_err got=%0d required=0", err_cnt); end
    if (cr_after !== 1'b1 || ov_after !== 1'b0) begin errors++; $display("FAIL nop_end cmd_ready=%b out_valid=%b required 1/0", cr_after, ov_after); end
    if (chk_err !== 1'b0) begin errors++; $display("FAIL nop_chk_err got=%b required=0", chk_err); end
  endtask

  task automatic test_moves();
    int tm[6] = '{1, 2, 2, 3, 3, 1};
    int tk[6] = '{3, 5, 8, 6, 0, 0};
    int tl[6] = '{12, 20, 15, 25, 31, 31};
    for (int t = 0; t < 6; t++) begin
      do_route(tm[t], tk[t], tl[t], 0, 0, 0, -1);
      for (int b = 0; b < BEATS; b++) begin
        checks++;
        if (got[b] !== exp_beat(b)) begin
          errors++;
          $display("FAIL move m%0d k%0d l%0d beat%0d got=%h required=%h", tm[t], tk[t], tl[t], b, got[b], exp_beat(b));
        end
      end
      checks += 2;
      if (err_cnt != 0) begin errors++; $display("FAIL move_cmd_err m%0d got=%0d required=0", tm[t], err_cnt); end
      if (extra != 0) begin errors++; $display("FAIL move_extra_beats got=%0d required=0", extra); end
    end
  endtask

  task automatic test_backpressure();
    do_route(0, 0, 0, 1, 1, 0, -1);
    for (int b = 0; b < BEATS; b++) begin
      checks++;
      if (got[b] !== exp_beat(b)) begin errors++; $display("FAIL bp beat%0d got=%h required=%h", b, got[b], exp_beat(b)); end
    end
    checks += 4;
    if (stab != 0) begin errors++; $display("FAIL bp_stable changes=%0d required=0", stab); end
    if (crv != 0) begin errors++; $display("FAIL bp_cmd_ready_early count=%0d required=0", crv); end
    if (cr_after !== 1'b1) begin errors++; $display("FAIL bp_cmd_ready_after got=%b required=1", cr_after); end
    if (extra != 0) begin errors++; $display("FAIL bp_extra_beats got=%0d required=0", extra); end
  endtask

  task automatic test_random();
    int m, k, l;
    for (int t = 0; t < 12; t++) begin
      m = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        k = int'($urandom_range(0, N-1)); l = int'($urandom_range(0, N-1));
      end else begin
        k = int'($urandom_range(0, N-2)); l = int'($urandom_range(k+1, N-1));
      end
      do_route(m, k, l, 1, 2, 0, -1);
      for (int b = 0; b < BEATS; b++) begin
        checks++;
        if (got[b] !== exp_beat(b)) begin
          errors++;
          $display("FAIL rand m%0d k%0d l%0d beat%0d got=%h required=%h", m, k, l, b, got[b], exp_beat(b));
        end
      end
      checks += 2;
      if (err_cnt != ((m != 0 && !(k < l)) ? 1 : 0)) begin
        errors++; $display("FAIL rand_cmd_err m%0d k%0d l%0d got=%0d", m, k, l, err_cnt);
      end
      if (stab != 0) begin errors++; $display("FAIL rand_stable changes=%0d required=0", stab); end
    end
  endtask

  task automatic test_illegal_and_reset();
    int cnt;
    do_route(3, 20, 20, 0, 0, 0, -1);
    for (int b = 0; b < BEATS; b++) begin
      checks++;
      if (got[b] !== exp_beat(b)) begin errors++; $display("FAIL illegal beat%0d got=%h required=%h", b, got[b], exp_beat(b)); end
    end
    checks++;
    if (err_cnt != 1) begin errors++; $display("FAIL illegal_cmd_err pulses=%0d required=1", err_cnt); end
    do_route(0, 0, 0, 0, 0, 0, 1);
    checks++;
    if (out_data !== exp_beat(1)) begin errors++; $display("FAIL pre_reset_beat1 got=%h required=%h", out_data, exp_beat(1)); end
    reset = 1;
    @(posedge clk); #1;
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    if (cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got=%b required=0", cmd_ready); end
    reset = 0;
    @(posedge clk); #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_release_cmd_ready got=%b required=1", cmd_ready); end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != 0) begin errors++; $display("FAIL reset_partial_beats got=%0d required=0", cnt); end
  endtask

`ifdef ROUTE_OPT_CHECKSUM_EN
  task automatic test_checksum();
    do_route(2, 4, 29, 1, 0, 0, -1);
    checks++;
    if (chk_err !== 1'b0) begin errors++; $display("FAIL chk_clean got=%b required=0", chk_err); end
    do_route(0, 0, 0, 1, 0, 1, -1);
    checks++;
    if (chk_err !== 1'b1) begin errors++; $display("FAIL chk_flip got=%b required=1", chk_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_nop();
    test_moves();
    test_backpressure();
    test_random();
    test_illegal_and_reset();
`ifdef ROUTE_OPT_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
